// File: rtl/mem_burst_pkg.sv
// Shared types for the two-client burst arbiter: source ids, FSM states and
// the default burst data width.
package mem_burst_pkg;

    localparam int DEFAULT_DATA_BITS = 64;

    typedef enum logic [1:0] {
        SRC_C0_WR = 2'd0,
        SRC_C0_RD = 2'd1,
        SRC_C1_WR = 2'd2,
        SRC_C1_RD = 2'd3
    } src_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    // Odd source ids are the read direction.
    function automatic logic src_is_rd(input src_e s);
        return s[0];
    endfunction

endpackage

// File: rtl/mem_burst_if.sv
// One rd/wr burst port. The master issues bursts; the slave executes them.
// Handshake: req is a level held by the master until the matching finish;
// wr_burst_data_req pops one write word and rd_burst_data_valid delivers one
// read word in the cycle it is high; finish is a single-cycle pulse.
interface mem_burst_if
    import mem_burst_pkg::*;
#(
    parameter int DATA_BITS = DEFAULT_DATA_BITS,
    parameter int ADDR_BITS = 32,
    parameter int LEN_BITS  = 10
);
    logic                 rd_burst_req;
    logic                 wr_burst_req;
    logic [LEN_BITS-1:0]  rd_burst_len;
    logic [LEN_BITS-1:0]  wr_burst_len;
    logic [ADDR_BITS-1:0] rd_burst_addr;
    logic [ADDR_BITS-1:0] wr_burst_addr;
    logic [DATA_BITS-1:0] wr_burst_data;
    logic                 wr_burst_data_req;
    logic [DATA_BITS-1:0] rd_burst_data;
    logic                 rd_burst_data_valid;
    logic                 rd_burst_finish;
    logic                 wr_burst_finish;

    modport master (
        output rd_burst_req, wr_burst_req, rd_burst_len, wr_burst_len,
               rd_burst_addr, wr_burst_addr, wr_burst_data,
        input  wr_burst_data_req, rd_burst_data, rd_burst_data_valid,
               rd_burst_finish, wr_burst_finish
    );

    modport slave (
        input  rd_burst_req, wr_burst_req, rd_burst_len, wr_burst_len,
               rd_burst_addr, wr_burst_addr, wr_burst_data,
        output wr_burst_data_req, rd_burst_data, rd_burst_data_valid,
               rd_burst_finish, wr_burst_finish
    );
endinterface

// File: rtl/mem_burst_arbiter_rr_pick4.sv
// Combinational 4-way round-robin picker: first active request at or after
// the pointer, wrapping around the ring.
module rr_pick4 (
    input  logic [3:0] i_req,
    input  logic [1:0] i_ptr,
    output logic       o_valid,
    output logic [1:0] o_idx
);
    logic [1:0] w_cand;

    // Scan from the farthest offset down so the nearest hit is the last write.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = i_ptr;
        w_cand  = i_ptr;
        for (int i = 3; i >= 0; i--) begin
            w_cand = i_ptr + 2'(i);
            if (i_req[w_cand]) begin
                o_valid = 1'b1;
                o_idx   = w_cand;
            end
        end
    end
endmodule

// File: rtl/mem_burst_arbiter.sv
// Shares one downstream rd/wr burst port between two clients, one burst at a
// time, round-robin over c0_wr -> c0_rd -> c1_wr -> c1_rd, with a watchdog.
module mem_burst_arbiter
    import mem_burst_pkg::*;
#(
    parameter int MEM_DATA_BITS = DEFAULT_DATA_BITS,
    parameter int ADDR_BITS     = 32,
    parameter int LEN_BITS      = 10,
    parameter int TIMEOUT_BITS  = 16
)(
    input  logic              mem_clk,
    input  logic              rst_n,
    mem_burst_if.slave        c0,
    mem_burst_if.slave        c1,
    mem_burst_if.master       dn,
    output logic [1:0]        grant,
    output logic              busy,
    output logic              timeout_err,
    output state_e            o_dbg_state
);
    localparam logic [TIMEOUT_BITS-1:0] WD_MAX  = '1;
    localparam logic [TIMEOUT_BITS-1:0] WD_LAST = WD_MAX - TIMEOUT_BITS'(1);

    state_e                  r_state;
    src_e                    r_src;
    logic [1:0]              r_ptr;
    logic [ADDR_BITS-1:0]    r_addr;
    logic [LEN_BITS-1:0]     r_len;
    logic                    r_rd_req;
    logic                    r_wr_req;
    logic [1:0]              r_grant;
    logic                    r_busy;
    logic [TIMEOUT_BITS-1:0] r_wd;
    logic                    r_timeout;

    logic [3:0]              w_req_vec;
    logic                    w_pick_valid;
    logic [1:0]              w_pick_idx;
    logic [ADDR_BITS-1:0]    w_sel_addr;
    logic [LEN_BITS-1:0]     w_sel_len;
    logic                    w_act;
    logic                    w_dn_finish;

    assign w_req_vec = {c1.rd_burst_req, c1.wr_burst_req, c0.rd_burst_req, c0.wr_burst_req};

    rr_pick4 u_pick (
        .i_req   (w_req_vec),
        .i_ptr   (r_ptr),
        .o_valid (w_pick_valid),
        .o_idx   (w_pick_idx)
    );

    always_comb begin
        w_sel_addr = c0.wr_burst_addr;
        w_sel_len  = c0.wr_burst_len;
        case (w_pick_idx)
            2'd1: begin w_sel_addr = c0.rd_burst_addr; w_sel_len = c0.rd_burst_len; end
            2'd2: begin w_sel_addr = c1.wr_burst_addr; w_sel_len = c1.wr_burst_len; end
            2'd3: begin w_sel_addr = c1.rd_burst_addr; w_sel_len = c1.rd_burst_len; end
            default: ;
        endcase
    end

    // Only the finish of the granted direction ends the burst.
    assign w_act       = (r_state == ST_BUSY);
    assign w_dn_finish = w_act && (src_is_rd(r_src) ? dn.rd_burst_finish : dn.wr_burst_finish);

    always_ff @(posedge mem_clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_src     <= SRC_C0_WR;
            r_ptr     <= 2'd0;
            r_addr    <= '0;
            r_len     <= '0;
            r_rd_req  <= 1'b0;
            r_wr_req  <= 1'b0;
            r_grant   <= 2'b00;
            r_busy    <= 1'b0;
            r_wd      <= '0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_valid) begin
                        r_src    <= src_e'(w_pick_idx);
                        r_addr   <= w_sel_addr;
                        r_len    <= w_sel_len;
                        r_wr_req <= ~w_pick_idx[0];
                        r_rd_req <= w_pick_idx[0];
                        r_grant  <= w_pick_idx[1] ? 2'b10 : 2'b01;
                        r_busy   <= 1'b1;
                        r_wd     <= '0;
                        r_state  <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (w_dn_finish) begin
                        r_wr_req <= 1'b0;
                        r_rd_req <= 1'b0;
                        r_grant  <= 2'b00;
                        r_busy   <= 1'b0;
                        r_ptr    <= r_src + 2'd1;
                        r_state  <= ST_IDLE;
                    end else if (r_wd != WD_MAX) begin
                        // Saturating watchdog; the flag is sticky until reset.
                        r_wd <= r_wd + TIMEOUT_BITS'(1);
                        if (r_wd == WD_LAST) r_timeout <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign dn.rd_burst_req  = r_rd_req;
    assign dn.wr_burst_req  = r_wr_req;
    assign dn.rd_burst_addr = r_addr;
    assign dn.wr_burst_addr = r_addr;
    assign dn.rd_burst_len  = r_len;
    assign dn.wr_burst_len  = r_len;
    assign dn.wr_burst_data = (w_act && r_src == SRC_C0_WR) ? c0.wr_burst_data :
                              (w_act && r_src == SRC_C1_WR) ? c1.wr_burst_data : '0;

    // Strobes and finishes go only to the owner, in the same cycle.
    assign c0.wr_burst_data_req   = w_act && (r_src == SRC_C0_WR) && dn.wr_burst_data_req;
    assign c1.wr_burst_data_req   = w_act && (r_src == SRC_C1_WR) && dn.wr_burst_data_req;
    assign c0.rd_burst_data_valid = w_act && (r_src == SRC_C0_RD) && dn.rd_burst_data_valid;
    assign c1.rd_burst_data_valid = w_act && (r_src == SRC_C1_RD) && dn.rd_burst_data_valid;
    assign c0.wr_burst_finish     = w_act && (r_src == SRC_C0_WR) && dn.wr_burst_finish;
    assign c1.wr_burst_finish     = w_act && (r_src == SRC_C1_WR) && dn.wr_burst_finish;
    assign c0.rd_burst_finish     = w_act && (r_src == SRC_C0_RD) && dn.rd_burst_finish;
    assign c1.rd_burst_finish     = w_act && (r_src == SRC_C1_RD) && dn.rd_burst_finish;
    assign c0.rd_burst_data       = dn.rd_burst_data;
    assign c1.rd_burst_data       = dn.rd_burst_data;

    assign grant       = r_grant;
    assign busy        = r_busy;
    assign timeout_err = r_timeout;
    assign o_dbg_state = r_state;
endmodule
